// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe move controller: state encoding,
// winning-line masks and small helpers.
package tictactoe_pkg;

  typedef enum logic [3:0] {
    ST_CLEAR     = 4'd0,
    ST_IDLE      = 4'd1,
    ST_VALIDATE  = 4'd2,
    ST_WRITE     = 4'd3,
    ST_WAIT_REG  = 4'd4,
    ST_SCAN      = 4'd5,
    ST_RESULT    = 4'd6,
    ST_GAME_OVER = 4'd7
  } estado_t;

  localparam logic [8:0] FULL_BOARD = 9'h1FF;

  // Board bit n is square n, row-major, bit0 = top-left.
  localparam logic [8:0] LINEA_0 = 9'h007;  // {0,1,2}
  localparam logic [8:0] LINEA_1 = 9'h038;  // {3,4,5}
  localparam logic [8:0] LINEA_2 = 9'h1C0;  // {6,7,8}
  localparam logic [8:0] LINEA_3 = 9'h049;  // {0,3,6}
  localparam logic [8:0] LINEA_4 = 9'h092;  // {1,4,7}
  localparam logic [8:0] LINEA_5 = 9'h124;  // {2,5,8}
  localparam logic [8:0] LINEA_6 = 9'h111;  // {0,4,8}
  localparam logic [8:0] LINEA_7 = 9'h054;  // {2,4,6}

  function automatic logic [8:0] mascara_linea(input logic [2:0] idx);
    logic [8:0] m;
    case (idx)
      3'd0:    m = LINEA_0;
      3'd1:    m = LINEA_1;
      3'd2:    m = LINEA_2;
      3'd3:    m = LINEA_3;
      3'd4:    m = LINEA_4;
      3'd5:    m = LINEA_5;
      3'd6:    m = LINEA_6;
      default: m = LINEA_7;
    endcase
    return m;
  endfunction

  function automatic logic es_one_hot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/controlador_jugadas_if.sv
// Bundle between the click front end / board registers and the move controller.
//
// Handshake semantics: a request is the rising edge of click (level signal,
// sampled every cycle); it is accepted only while the controller is idle,
// otherwise it is dropped. cuadro is captured in the request cycle. All
// controller outputs named *_x/_o strobes, resetPosiciones, move_rejected and
// result_valid are single-cycle pulses with no back-pressure; the board
// registers must accept a strobe in the cycle it appears. restart is a level
// request that overrides everything.
interface controlador_jugadas_if;
  logic       restart;
  logic       click;
  logic [8:0] cuadro;
  logic [8:0] posiciones_x;
  logic [8:0] posiciones_o;
  logic [8:0] almacenar_x;
  logic [8:0] almacenar_o;
  logic       resetPosiciones;
  logic       turnoX;
  logic       busy;
  logic       move_rejected;
  logic       result_valid;
  logic       ganador_x;
  logic       ganador_o;
  logic       empate;
  logic [2:0] linea_ganadora;
  logic [3:0] estado;

  modport master (
    output restart, click, cuadro, posiciones_x, posiciones_o,
    input  almacenar_x, almacenar_o, resetPosiciones, turnoX, busy,
           move_rejected, result_valid, ganador_x, ganador_o, empate,
           linea_ganadora, estado
  );

  modport slave (
    input  restart, click, cuadro, posiciones_x, posiciones_o,
    output almacenar_x, almacenar_o, resetPosiciones, turnoX, busy,
           move_rejected, result_valid, ganador_x, ganador_o, empate,
           linea_ganadora, estado
  );
endinterface

// File: rtl/linea_check.sv
// Combinational test of one winning line (selected by idx) against a board.
module linea_check (
  input  logic [8:0] board,
  input  logic [2:0] idx,
  output logic       match
);
  import tictactoe_pkg::*;

  logic [8:0] mascara;

  // Line matches when every square of its mask is occupied.
  always_comb begin
    mascara = mascara_linea(idx);
    match   = (board & mascara) == mascara;
  end
endmodule

// File: rtl/controlador_jugadas.sv
// Move sequencer: captures clicks, validates them, writes the board of the
// player on turn, scans the 8 lines with fixed latency and reports the result.
module controlador_jugadas #(
  parameter bit START_X         = 1'b1,
  parameter bit ALTERNATE_START = 1'b1
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  controlador_jugadas_if.slave  bus
);
  import tictactoe_pkg::*;

  estado_t    state_q, state_d;
  logic       click_prev;
  logic [8:0] cuadro_q;
  logic [2:0] scan_cnt;
  logic       hit_found;
  logic [2:0] hit_idx;
  logic       turno_q;
  logic       next_starter;
  logic       gx_q, go_q, emp_q;
  logic [2:0] linea_q;
  logic       rp_q;
  logic       arranque;      // set by reset so the reset CLEAR also pulses
  logic       req;
  logic       legal;
  logic       line_match;
  logic       entrada_clear; // cycle before a fresh CLEAR (one pulse per entry)
  logic [8:0] ocupadas;
  logic [8:0] board_mov;

  assign req       = bus.click & ~click_prev;
  assign ocupadas  = bus.posiciones_x | bus.posiciones_o;
  assign legal     = es_one_hot(cuadro_q) && ((cuadro_q & ocupadas) == 9'd0);
  assign board_mov = turno_q ? bus.posiciones_x : bus.posiciones_o;
  assign entrada_clear = (state_d == ST_CLEAR) && ((state_q != ST_CLEAR) || arranque);

  linea_check u_linea_check (
    .board (board_mov),
    .idx   (scan_cnt),
    .match (line_match)
  );

  // State register.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state_q <= ST_CLEAR;
    else          state_q <= state_d;
  end

  // Next-state logic; restart overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:     state_d = arranque ? ST_CLEAR : ST_IDLE;
      ST_IDLE:      if (req) state_d = ST_VALIDATE;
      ST_VALIDATE:  state_d = legal ? ST_WRITE : ST_IDLE;
      ST_WRITE:     state_d = ST_WAIT_REG;
      ST_WAIT_REG:  state_d = ST_SCAN;
      ST_SCAN:      if (scan_cnt == 3'd7) state_d = ST_RESULT;
      ST_RESULT:    state_d = (hit_found || (ocupadas == FULL_BOARD)) ? ST_GAME_OVER : ST_IDLE;
      ST_GAME_OVER: state_d = ST_GAME_OVER;
      default:      state_d = ST_CLEAR;
    endcase
    if (bus.restart) state_d = ST_CLEAR;
  end

  // Datapath: click edge, square latch, line scan, turn and outcome flags.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      click_prev   <= 1'b0;
      cuadro_q     <= 9'd0;
      scan_cnt     <= 3'd0;
      hit_found    <= 1'b0;
      hit_idx      <= 3'd0;
      turno_q      <= START_X;
      next_starter <= START_X;
      gx_q         <= 1'b0;
      go_q         <= 1'b0;
      emp_q        <= 1'b0;
      linea_q      <= 3'd0;
      rp_q         <= 1'b0;
      arranque     <= 1'b1;
    end else begin
      click_prev <= bus.click;
      rp_q       <= entrada_clear;
      if (state_q == ST_CLEAR) arranque <= 1'b0;
      if (state_q == ST_IDLE && req) cuadro_q <= bus.cuadro;

      if (state_q == ST_WAIT_REG) begin
        scan_cnt  <= 3'd0;
        hit_found <= 1'b0;
        hit_idx   <= 3'd0;
      end else if (state_q == ST_SCAN) begin
        scan_cnt <= scan_cnt + 3'd1;
        if (line_match && !hit_found) begin
          hit_found <= 1'b1;
          hit_idx   <= scan_cnt;
        end
      end

      if (entrada_clear) begin
        turno_q <= next_starter;
        if (ALTERNATE_START) next_starter <= ~next_starter;
        gx_q    <= 1'b0;
        go_q    <= 1'b0;
        emp_q   <= 1'b0;
        linea_q <= 3'd0;
      end else if (state_q == ST_RESULT) begin
        if (hit_found) begin
          if (turno_q) gx_q <= 1'b1;
          else         go_q <= 1'b1;
          linea_q <= hit_idx;
        end else if (ocupadas == FULL_BOARD) begin
          emp_q <= 1'b1;
        end else begin
          turno_q <= ~turno_q;
        end
      end
    end
  end

  assign bus.almacenar_x     = (state_q == ST_WRITE && turno_q && !bus.restart) ? cuadro_q : 9'd0;
  assign bus.almacenar_o     = (state_q == ST_WRITE && !turno_q && !bus.restart) ? cuadro_q : 9'd0;
  assign bus.move_rejected   = (state_q == ST_VALIDATE) && !legal && !bus.restart;
  assign bus.result_valid    = (state_q == ST_RESULT) && !bus.restart;
  assign bus.resetPosiciones = rp_q;
  assign bus.turnoX          = turno_q;
  assign bus.busy            = (state_q inside {ST_CLEAR, ST_VALIDATE, ST_WRITE,
                                                ST_WAIT_REG, ST_SCAN, ST_RESULT});
  assign bus.ganador_x       = gx_q;
  assign bus.ganador_o       = go_q;
  assign bus.empate          = emp_q;
  assign bus.linea_ganadora  = linea_q;
  assign bus.estado          = state_q;

endmodule

// File: tb/tb_controlador_jugadas.sv
// Self-checking bench for controlador_jugadas: directed games plus random games
// compared against a square/line-list model of tic-tac-toe rules.
module tb_controlador_jugadas;

  localparam bit START_X = 1'b1;
  localparam bit ALT     = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  controlador_jugadas_if bus();

  controlador_jugadas #(.START_X(START_X), .ALTERNATE_START(ALT)) dut (
    .clk_100MHz (clk),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  // Board registers (Tablero) living in the environment.
  logic [8:0] px = 9'd0;
  logic [8:0] po = 9'd0;
  assign bus.posiciones_x = px;
  assign bus.posiciones_o = po;
  always @(posedge clk) begin
    if (bus.resetPosiciones) begin
      px <= 9'd0;
      po <= 9'd0;
    end else begin
      px <= px | bus.almacenar_x;
      po <= po | bus.almacenar_o;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected {x, o} pair.
  logic [17:0] exp_q[$];
  always @(negedge clk) begin
    if ((bus.almacenar_x | bus.almacenar_o) != 9'd0) begin
      if (exp_q.size() == 0)
        chk("stb_unexpected", {14'd0, bus.almacenar_x, bus.almacenar_o}, 32'd0);
      else
        chk("stb_value", {14'd0, bus.almacenar_x, bus.almacenar_o}, {14'd0, exp_q.pop_front()});
    end
  end

  // ---------------- reference model ----------------
  int lineas [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  bit mx [9];
  bit mo [9];
  bit m_turno, m_ns, m_over, m_gx, m_go, m_emp;
  int m_linea;

  function automatic int buscar_linea(input bit es_x);
    for (int l = 0; l < 8; l++) begin
      bit ok;
      ok = 1'b1;
      for (int j = 0; j < 3; j++)
        if (es_x ? !mx[lineas[l][j]] : !mo[lineas[l][j]]) ok = 1'b0;
      if (ok) return l;
    end
    return -1;
  endfunction

  function automatic bit tablero_lleno();
    for (int i = 0; i < 9; i++) if (!mx[i] && !mo[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] vec(input bit es_x);
    logic [8:0] v;
    for (int i = 0; i < 9; i++) v[i] = es_x ? mx[i] : mo[i];
    return v;
  endfunction

  task automatic modelo_nueva_partida();
    for (int i = 0; i < 9; i++) begin mx[i] = 1'b0; mo[i] = 1'b0; end
    m_turno = m_ns;
    if (ALT) m_ns = !m_ns;
    m_over = 1'b0; m_gx = 1'b0; m_go = 1'b0; m_emp = 1'b0; m_linea = 0;
  endtask

  task automatic modelo_reset();
    m_ns = START_X;
    modelo_nueva_partida();
  endtask

  task automatic modelo_jugada(input logic [8:0] v, output bit legal, output bit rej);
    int n, k, l;
    n = 0; k = 0;
    for (int i = 0; i < 9; i++) if (v[i]) begin n++; k = i; end
    legal = 1'b0; rej = 1'b0;
    if (!m_over) begin
      if (n == 1 && !mx[k] && !mo[k]) legal = 1'b1;
      else rej = 1'b1;
    end
    if (legal) begin
      exp_q.push_back(m_turno ? {v, 9'd0} : {9'd0, v});
      if (m_turno) mx[k] = 1'b1; else mo[k] = 1'b1;
      l = buscar_linea(m_turno);
      if (l >= 0) begin
        if (m_turno) m_gx = 1'b1; else m_go = 1'b1;
        m_linea = l; m_over = 1'b1;
      end else if (tablero_lleno()) begin
        m_emp = 1'b1; m_over = 1'b1;
      end else begin
        m_turno = !m_turno;
      end
    end
  endtask

  task automatic comprobar_estado();
    chk("ganador_x", bus.ganador_x, m_gx);
    chk("ganador_o", bus.ganador_o, m_go);
    chk("empate", bus.empate, m_emp);
    chk("turnoX", bus.turnoX, m_turno);
    chk("busy_idle", bus.busy, 0);
    chk("board_x", px, vec(1'b1));
    chk("board_o", po, vec(1'b0));
    if (m_gx || m_go) chk("linea", bus.linea_ganadora, m_linea);
  endtask

  // ---------------- driver tasks ----------------
  task automatic aplicar_reset();
    int cnt;
    reset_n = 1'b0;
    #1;
    chk("rst_alm_x", bus.almacenar_x, 0);
    chk("rst_alm_o", bus.almacenar_o, 0);
    chk("rst_rp", bus.resetPosiciones, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_rej", bus.move_rejected, 0);
    chk("rst_flags", {bus.ganador_x, bus.ganador_o, bus.empate}, 0);
    chk("rst_linea", bus.linea_ganadora, 0);
    chk("rst_turno", bus.turnoX, START_X);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    modelo_reset();
    cnt = 0;
    repeat (6) begin @(negedge clk); cnt += int'(bus.resetPosiciones); end
    chk("rst_rp_pulses", cnt, 1);
    comprobar_estado();
  endtask

  task automatic nueva_partida();
    int cnt;
    bus.restart = 1'b1;
    @(negedge clk);
    cnt = int'(bus.resetPosiciones);
    bus.restart = 1'b0;
    repeat (4) begin @(negedge clk); cnt += int'(bus.resetPosiciones); end
    modelo_nueva_partida();
    chk("restart_rp_pulses", cnt, 1);
    comprobar_estado();
  endtask

  task automatic jugada(input logic [8:0] v);
    bit legal, rej, was_over;
    int rej_at, stb_at, rv_at, n_rej, n_rv;
    was_over = m_over;
    modelo_jugada(v, legal, rej);
    rej_at = -1; stb_at = -1; rv_at = -1; n_rej = 0; n_rv = 0;
    bus.cuadro = v;
    bus.click  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_t1", bus.busy, !was_over);
      if (bus.move_rejected) begin n_rej++; if (rej_at < 0) rej_at = i; end
      if (bus.result_valid) begin n_rv++; if (rv_at < 0) rv_at = i; end
      if ((bus.almacenar_x | bus.almacenar_o) != 9'd0 && stb_at < 0) stb_at = i;
      if (i == 2) bus.click = 1'b0;
    end
    chk("rej_at", rej_at, rej ? 1 : -1);
    chk("n_rej", n_rej, rej ? 1 : 0);
    chk("stb_at", stb_at, legal ? 2 : -1);
    chk("rv_at", rv_at, legal ? 12 : -1);
    chk("n_rv", n_rv, legal ? 1 : 0);
    comprobar_estado();
  endtask

  task automatic click_sostenido(input logic [8:0] v);
    bit legal, rej;
    int n_stb, n_rv;
    modelo_jugada(v, legal, rej);
    n_stb = 0; n_rv = 0;
    bus.cuadro = v;
    bus.click  = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if ((bus.almacenar_x | bus.almacenar_o) != 9'd0) n_stb++;
      n_rv += int'(bus.result_valid);
    end
    bus.click = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_n_stb", n_stb, legal ? 1 : 0);
    chk("held_n_rv", n_rv, legal ? 1 : 0);
    comprobar_estado();
  endtask

  task automatic restart_en_escritura(input logic [8:0] v);
    int cnt;
    bus.cuadro = v;
    bus.click  = 1'b1;
    @(negedge clk);
    bus.click = 1'b0;
    @(posedge clk);
    #1 bus.restart = 1'b1;
    @(negedge clk);
    chk("rs_alm_x", bus.almacenar_x, 0);
    chk("rs_alm_o", bus.almacenar_o, 0);
    cnt = int'(bus.resetPosiciones);
    @(posedge clk);
    #1 bus.restart = 1'b0;
    repeat (5) begin @(negedge clk); cnt += int'(bus.resetPosiciones); end
    modelo_nueva_partida();
    chk("rs_rp_pulses", cnt, 1);
    comprobar_estado();
  endtask

  task automatic reset_en_scan(input logic [8:0] v);
    bit legal, rej;
    modelo_jugada(v, legal, rej);
    bus.cuadro = v;
    bus.click  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) bus.click = 1'b0;
    end
    chk("scan_state", bus.estado, 5);
    aplicar_reset();
  endtask

  task automatic juego_aleatorio();
    logic [8:0] v;
    int libres[$];
    int ocup[$];
    int r;
    for (int m = 0; m < 25 && !m_over; m++) begin
      libres.delete(); ocup.delete();
      for (int i = 0; i < 9; i++) if (mx[i] || mo[i]) ocup.push_back(i); else libres.push_back(i);
      r = int'($urandom_range(0, 99));
      v = 9'd0;
      if (r < 70 || (r < 85 && ocup.size() == 0))
        v[libres[$urandom_range(0, libres.size() - 1)]] = 1'b1;
      else if (r < 85)
        v[ocup[$urandom_range(0, ocup.size() - 1)]] = 1'b1;
      else
        v = 9'($urandom_range(0, 511));
      jugada(v);
    end
    jugada(9'($urandom_range(0, 511)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.restart = 1'b0;
    bus.click   = 1'b0;
    bus.cuadro  = 9'd0;
    aplicar_reset();

    // X opens, then X wins on the top row; a later click is ignored.
    jugada(9'h001);
    jugada(9'h008); jugada(9'h002); jugada(9'h010); jugada(9'h004);
    jugada(9'h040);

    // O starts; occupied and multi-hot clicks are rejected.
    nueva_partida();
    jugada(9'h010); jugada(9'h001);
    jugada(9'h001); jugada(9'h003);

    // Full board without a line: draw.
    nueva_partida();
    jugada(9'h001); jugada(9'h002); jugada(9'h004); jugada(9'h010); jugada(9'h008);
    jugada(9'h020); jugada(9'h080); jugada(9'h040); jugada(9'h100);

    // Held click gives one move, then random play.
    nueva_partida();
    click_sostenido(9'h010);
    juego_aleatorio();

    // Win on the ninth move is a win, not a draw.
    nueva_partida();
    jugada(9'h001); jugada(9'h002); jugada(9'h004); jugada(9'h008); jugada(9'h010);
    jugada(9'h020); jugada(9'h080); jugada(9'h040); jugada(9'h100);

    // Restart during the write cycle, then reset during the scan.
    nueva_partida();
    restart_en_escritura(9'h100);
    reset_en_scan(9'h010);

    for (int g = 0; g < 8; g++) begin
      juego_aleatorio();
      nueva_partida();
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
